// File: rtl/load_store_unit.sv
// Load/store initiator for a word-wide, byte-addressed, big-endian data memory.
// Sub-word stores are done as read-modify-write. Loads return sign- or zero-extended results.
module load_store_unit #(
   parameter int READ_LATENCY = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [2:0]  i_req_op,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [4:0]  i_req_rd,
   output logic [31:0] o_r_mem_addr,
   output logic        o_r_mem_en,
   input  logic [31:0] i_r_mem_data,
   output logic [31:0] o_w_mem_addr,
   output logic [31:0] o_w_mem_data,
   output logic        o_w_mem_en,
   output logic        o_resp_valid,
   output logic [31:0] o_resp_data,
   output logic [4:0]  o_resp_rd,
   output logic        o_resp_err
);

   localparam int CW = $clog2(READ_LATENCY + 1);
   localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_inc;
   logic          lat_hit;
   logic          illegal_req;

   logic          we_q, err_q;
   logic [2:0]    op_q;
   logic [31:0]   addr_q, wdata_q, rdata_q;
   logic [4:0]    rd_q;
   logic [31:0]   load_data, store_word;

   assign cnt_inc = cnt_q + CW'(1);
   assign lat_hit = (cnt_inc == LAT);

   always_comb begin
      case (i_req_op)
         OP_B, OP_H, OP_W: illegal_req = 1'b0;
         OP_BU, OP_HU:     illegal_req = i_req_we;
         default:          illegal_req = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == RD_WAIT && !lat_hit) cnt_q <= cnt_inc;
         else                                cnt_q <= '0;
      end
   end

   // NOTE: request fields are plain datapath registers; they are only observed once the FSM
   // has left IDLE, so they need no reset.
   always_ff @(posedge i_clk) begin
      if (state_q == IDLE && i_req_valid) begin
         we_q    <= i_req_we;
         op_q    <= i_req_op;
         addr_q  <= i_req_addr;
         wdata_q <= i_req_wdata;
         rd_q    <= i_req_rd;
         err_q   <= illegal_req;
      end
      if (state_q == RD_WAIT && lat_hit) rdata_q <= i_r_mem_data;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               if (illegal_req)                      state_d = RESP;
               else if (i_req_we && i_req_op == OP_W) state_d = WRITE;
               else                                  state_d = RD_WAIT;
            end
         end
         RD_WAIT: if (lat_hit) state_d = we_q ? WRITE : RESP;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Big-endian: the addressed byte sits in rdata[31:24].
   always_comb begin
      load_data = '0;
      case (op_q)
         OP_B:    load_data = {{24{rdata_q[31]}}, rdata_q[31:24]};
         OP_H:    load_data = {{16{rdata_q[31]}}, rdata_q[31:16]};
         OP_W:    load_data = rdata_q;
         OP_BU:   load_data = {24'd0, rdata_q[31:24]};
         OP_HU:   load_data = {16'd0, rdata_q[31:16]};
         default: load_data = '0;
      endcase
   end

   always_comb begin
      store_word = wdata_q;
      case (op_q)
         OP_B:    store_word = {wdata_q[7:0], rdata_q[23:0]};
         OP_H:    store_word = {wdata_q[15:0], rdata_q[15:0]};
         default: store_word = wdata_q;
      endcase
   end

   always_comb begin
      o_req_ready  = 1'b0;
      o_r_mem_addr = '0;
      o_r_mem_en   = 1'b0;
      o_w_mem_addr = '0;
      o_w_mem_data = '0;
      o_w_mem_en   = 1'b0;
      o_resp_valid = 1'b0;
      o_resp_data  = '0;
      o_resp_rd    = '0;
      o_resp_err   = 1'b0;
      if (!i_rst) begin
         case (state_q)
            IDLE: o_req_ready = 1'b1;
            RD_WAIT: begin
               o_r_mem_en   = 1'b1;
               o_r_mem_addr = addr_q;
            end
            WRITE: begin
               o_w_mem_en   = 1'b1;
               o_w_mem_addr = addr_q;
               o_w_mem_data = store_word;
            end
            RESP: begin
               o_resp_valid = 1'b1;
               o_resp_rd    = rd_q;
               o_resp_err   = err_q;
               o_resp_data  = (we_q || err_q) ? 32'd0 : load_data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the byte-addressed data memory interface. Accepts one load or store request at a time from the execute stage and turns it into memory read and write transactions. Returns load results with sign or zero extension. Byte and halfword stores are done as read-modify-write, because the memory writes only whole words (4 bytes starting at the given address, big-endian: the byte at addr goes in bits [31:24]).

## Interface
Parameters:
- READ_LATENCY, 1, cycles from a driven read address until i_r_mem_data is valid; must be ≥1

Ports:
- i_clk  in  1  clock; all state updates on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  unit can accept a request; high only in IDLE
- i_req_we  in  1  1 = store, 0 = load
- i_req_op  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- i_req_addr  in  32  byte address; no alignment required
- i_req_wdata  in  32  store data; B uses [7:0], H uses [15:0]
- i_req_rd  in  5  destination tag, returned with the response
- o_r_mem_addr  out  32  memory read address
- o_r_mem_en  out  1  read in progress
- i_r_mem_data  in  32  memory read data
- o_w_mem_addr  out  32  memory write address
- o_w_mem_data  out  32  memory write word
- o_w_mem_en  out  1  write strobe, 1 cycle
- o_resp_valid  out  1  one-cycle completion pulse
- o_resp_data  out  32  load result; 0 for stores
- o_resp_rd  out  5  tag of the completed request
- o_resp_err  out  1  illegal op; no memory access was made

## Operation
- States: IDLE, RD_WAIT, WRITE, RESP.
- IDLE:
  - On i_req_valid && o_req_ready, latch we, op, addr, wdata and rd.
  - Next state: illegal op (011, 11x, or BU/HU with we=1) → RESP with err=1. Store W → WRITE. Anything else → RD_WAIT.
- RD_WAIT:
  - Drive o_r_mem_addr = latched addr and o_r_mem_en = 1.
  - Counter runs 1..READ_LATENCY. On the edge where the count equals READ_LATENCY, capture i_r_mem_data into rdata.
  - Loads go to RESP. Sub-word stores go to WRITE.
- WRITE:
  - Drive o_w_mem_en = 1 and o_w_mem_addr = addr.
  - Write data: W = wdata. H = {wdata[15:0], rdata[15:0]}. B = {wdata[7:0], rdata[23:0]}.
  - Next state RESP.
- RESP:
  - o_resp_valid = 1 and o_resp_rd = tag, then IDLE.
- Load extraction from rdata:
  - W = rdata.
  - H = sign-extend rdata[31:16]; HU = zero-extend rdata[31:16].
  - B = sign-extend rdata[31:24]; BU = zero-extend rdata[31:24].
- Memory outputs are 0 when not in their active state: o_r_mem_addr outside RD_WAIT; o_w_mem_addr and o_w_mem_data outside WRITE. o_resp_data and o_resp_err are 0 outside RESP.
- All outputs are decoded from registered state and latched fields; there is no combinational path from req inputs to the memory ports.

## Timing
- Reset:
  - State goes to IDLE and the counter clears.
  - While i_rst is high: o_req_ready = 0, and all of o_r_mem_en, o_w_mem_en, o_resp_valid, o_resp_err, addresses, data and o_resp_rd = 0.
  - o_req_ready rises in the first cycle after i_rst deasserts.
- Reset mid-operation abandons the request. A reset edge in RD_WAIT or WRITE means no o_w_mem_en and no o_resp_valid in the following cycle.
- Accept edge = cycle 0. Responses arrive at:
  - Load: o_resp_valid in cycle READ_LATENCY+1.
  - Store W: o_w_mem_en in cycle 1, o_resp_valid in cycle 2.
  - Store B/H: o_w_mem_en in cycle READ_LATENCY+1, o_resp_valid in cycle READ_LATENCY+2.
  - Illegal op: o_resp_valid with err in cycle 1.
- o_req_ready returns high in the cycle after RESP. A request held valid through RESP is accepted on that next edge, so the back-to-back spacing is latency+1 cycles.
- Requests presented while o_req_ready=0 are ignored; the requester must hold them.
- Address arithmetic is 32-bit and passed through unmodified. Memory-side wrap at the top of its range is the memory's concern.

## Test plan
- LW at addr 0x10, memory bytes 0x10..0x13 = DE AD BE EF, READ_LATENCY=1 → o_r_mem_en in cycle 1, then o_resp_data=0xDEADBEEF with o_resp_valid in cycle 2.
- LB and then LBU at addr 0x20 holding 0x80 → 0xFFFFFF80, then 0x00000080. LH at 0x20 holding 80 01 → 0xFFFF8001.
- SB wdata=0x000000AA at 0x30, where the word at 0x30 = 11 22 33 44 → a single write of 0xAA223344 to 0x30 in cycle READ_LATENCY+1. A later LW at 0x30 returns 0xAA223344.
- SW 0xCAFEBABE at 0x40 with i_req_valid held high into a following LW 0x40 → write in cycle 1, resp in cycle 2, LW accepted in cycle 3, and it returns 0xCAFEBABE.
- Assert i_rst during RD_WAIT of an SH, READ_LATENCY=3 → no o_w_mem_en and no o_resp_valid afterwards; o_req_ready=1 in the cycle after reset drops.
- i_req_op=011 load, and BU with we=1 → o_resp_err=1 with o_resp_valid in cycle 1; o_r_mem_en and o_w_mem_en stay 0 throughout.
